// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
//
// Consumes the clean level from a per-button debouncer and turns it into
// one-cycle event pulses: press/release edges plus classified short, long
// and double presses. Downstream control logic can use these pulses directly
// without any edge detection of its own.
//
// Optional feature:
//   AUTO_REPEAT_EN - when defined, a long-held button emits repeat_pulse every
//                    REPEAT_CYCLES cycles after long_press. When undefined,
//                    repeat_pulse is tied to 0 and no repeat counter is built.
//
// Every output comes straight from a flop. An edge sampled at clock edge k
// shows up as a pulse during the cycle that follows edge k.
// -----------------------------------------------------------------------------
module btn_event_decoder #(
    parameter int LONG_CYCLES   = 2_000_000,
    parameter int GAP_CYCLES    = 1_000_000,
    parameter int REPEAT_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_pulse,
    output logic busy
);

    // Size the shared counter for the largest terminal value in use.
    localparam int MAX_LG  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESSED     = 3'd1,
        ST_LONG_HELD   = 3'd2,
        ST_WAIT_GAP    = 3'd3,
        ST_SECOND_HELD = 3'd4
    } state_e;

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             btn_q_r;

    logic             press_r;
    logic             release_r;
    logic             short_r;
    logic             long_r;
    logic             double_r;
    logic             busy_r;
`ifdef AUTO_REPEAT_EN
    logic             repeat_r;
`endif

    logic             rise_s;
    logic             fall_s;

    // Edge detection against the previous sampled level. btn_q_r resets to 1
    // so a button held through reset release does not look like a new press.
    assign rise_s = btn_db & ~btn_q_r;
    assign fall_s = ~btn_db & btn_q_r;

    // Classification FSM: state, shared counter and all registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            btn_q_r   <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
            double_r  <= 1'b0;
            busy_r    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeat_r  <= 1'b0;
`endif
        end else begin
            btn_q_r   <= btn_db;
            // Pulses are single-cycle: clear by default, set only on events.
            press_r   <= 1'b0;
            release_r <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
            double_r  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeat_r  <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        press_r <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_PRESSED;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                ST_PRESSED: begin
                    // A release on the terminal cycle beats long detection.
                    if (fall_s) begin
                        release_r <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_WAIT_GAP;
                        busy_r    <= 1'b1;
                    end else if (cnt_r == LONG_LAST) begin
                        long_r    <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_LONG_HELD;
                        busy_r    <= 1'b1;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                        state_r   <= ST_PRESSED;
                        busy_r    <= 1'b1;
                    end
                end

                ST_LONG_HELD: begin
                    // Release always wins over a repeat falling on the same cycle.
                    if (fall_s) begin
                        release_r <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        if (cnt_r == REP_LAST) begin
                            repeat_r <= 1'b1;
                            cnt_r    <= CNT_ZERO;
                        end else begin
                            cnt_r    <= cnt_r + CNT_ONE;
                        end
`else
                        cnt_r     <= CNT_ZERO;
`endif
                        state_r   <= ST_LONG_HELD;
                        busy_r    <= 1'b1;
                    end
                end

                ST_WAIT_GAP: begin
                    // A re-press on the terminal cycle still counts as a double.
                    if (rise_s) begin
                        press_r  <= 1'b1;
                        double_r <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= ST_SECOND_HELD;
                        busy_r   <= 1'b1;
                    end else if (cnt_r == GAP_LAST) begin
                        short_r  <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end else begin
                        cnt_r    <= cnt_r + CNT_ONE;
                        state_r  <= ST_WAIT_GAP;
                        busy_r   <= 1'b1;
                    end
                end

                ST_SECOND_HELD: begin
                    // The second press of a double is never classified as long.
                    if (fall_s) begin
                        release_r <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end else begin
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_SECOND_HELD;
                        busy_r    <= 1'b1;
                    end
                end

                default: begin
                    // Unused encodings recover quietly to IDLE.
                    cnt_r   <= CNT_ZERO;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign short_press   = short_r;
    assign long_press    = long_r;
    assign double_press  = double_r;
    assign busy          = busy_r;
`ifdef AUTO_REPEAT_EN
    assign repeat_pulse  = repeat_r;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_event_decoder
//
// Scoreboard bench. Each cycle the stimulus side drives btn_db/rst_n, runs a
// timestamp-based reference model of the press classification rules and
// pushes the expected output vector. A separate monitor pops one entry per
// cycle, shortly after the clock edge, and compares it with the DUT outputs.
// Vector layout: {press, release, short, long, double, repeat, busy}.
// -----------------------------------------------------------------------------
module tb_btn_event_decoder;

    localparam int LONG   = 8;
    localparam int GAP    = 5;
    localparam int REPEAT = 4;

    logic clk;
    logic rst_n;
    logic btn_db;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_press;
    logic repeat_pulse;
    logic busy;

    btn_event_decoder #(
        .LONG_CYCLES  (LONG),
        .GAP_CYCLES   (GAP),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_db       (btn_db),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0] exp_q[$];

    // Reference model: which phase of a press session we are in, and the
    // timestamp (sample index) at which that phase began.
    localparam int M_NONE  = 0;  // no session
    localparam int M_HOLD1 = 1;  // first press held, measured from its rise
    localparam int M_GAP   = 2;  // released, measured from the release
    localparam int M_LONG  = 3;  // long reached, measured from the long event
    localparam int M_HOLD2 = 4;  // second press of a double

    int m_t;
    int m_mode;
    int m_mark;
    bit m_prev;

    task automatic model_reset();
        m_mode = M_NONE;
        m_mark = 0;
        m_prev = 1'b1;
    endtask

    task automatic model_sample(input bit b, output logic [6:0] e);
        bit rise;
        bit fall;
        e    = 7'b0;
        m_t  = m_t + 1;
        rise = b && !m_prev;
        fall = !b && m_prev;
        m_prev = b;
        case (m_mode)
            M_NONE: begin
                if (rise) begin e[6] = 1'b1; m_mode = M_HOLD1; m_mark = m_t; end
            end
            M_HOLD1: begin
                if (fall) begin
                    e[5] = 1'b1; m_mode = M_GAP; m_mark = m_t;
                end else if (m_t - m_mark == LONG) begin
                    e[3] = 1'b1; m_mode = M_LONG; m_mark = m_t;
                end
            end
            M_GAP: begin
                if (rise) begin
                    e[6] = 1'b1; e[2] = 1'b1; m_mode = M_HOLD2;
                end else if (m_t - m_mark == GAP) begin
                    e[4] = 1'b1; m_mode = M_NONE;
                end
            end
            M_LONG: begin
                if (fall) begin
                    e[5] = 1'b1; m_mode = M_NONE;
                end
`ifdef AUTO_REPEAT_EN
                else if (((m_t - m_mark) % REPEAT) == 0) begin
                    e[1] = 1'b1;
                end
`endif
            end
            M_HOLD2: begin
                if (fall) begin e[5] = 1'b1; m_mode = M_NONE; end
            end
            default: m_mode = M_NONE;
        endcase
        e[0] = (m_mode != M_NONE);
    endtask

    // One stimulus cycle: drive at the falling edge, push the expectation.
    task automatic step(input logic b, input logic r);
        logic [6:0] e;
        @(negedge clk);
        btn_db = b;
        rst_n  = r;
        if (!r) begin
            model_reset();
            exp_q.push_back(7'b0);
            #1;
            checks++;
            if ({press_pulse, release_pulse, short_press, long_press,
                 double_press, repeat_pulse, busy} !== 7'b0) begin
                errors++;
                $display("FAIL async_reset cyc=%0d act=%b exp=0000000", cyc,
                         {press_pulse, release_pulse, short_press, long_press,
                          double_press, repeat_pulse, busy});
            end
        end else begin
            model_sample(b, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    task automatic hold_reset(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    // Monitor: compares one expectation per cycle just after the active edge.
    logic [6:0] mon_exp;
    logic [6:0] mon_act;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {press_pulse, release_pulse, short_press, long_press,
                           double_press, repeat_pulse, busy};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d act=%b exp=%b", cyc, mon_act, mon_exp);
                end
                checks++;
                if ($countones(mon_act[4:1]) > 1) begin
                    errors++;
                    $display("FAIL event_exclusive cyc=%0d act=%b exp=at_most_one", cyc, mon_act[4:1]);
                end
            end
        end
    end

    initial begin
        int len;
        logic lvl;
        rst_n  = 1'b0;
        btn_db = 1'b0;
        m_t    = 0;
        model_reset();

        // Button held through reset release: no events at all.
        hold_reset(1'b1, 3);
        run(1'b1, 20);
        run(1'b0, 6);

        // Short press.
        run(1'b1, 3);
        run(1'b0, 10);

        // Double press.
        run(1'b1, 3);
        run(1'b0, 2);
        run(1'b1, 3);
        run(1'b0, 8);

        // Long press with optional auto-repeat.
        run(1'b1, 20);
        run(1'b0, 8);

        // Release on the last cycle before long: no long_press.
        run(1'b1, LONG);
        run(1'b0, 10);
        // One cycle longer: long_press fires.
        run(1'b1, LONG + 1);
        run(1'b0, 4);

        // Re-press on the last gap cycle: double, no short.
        run(1'b1, 3);
        run(1'b0, GAP);
        run(1'b1, 3);
        run(1'b0, 10);
        // One gap cycle later: short first, then a fresh press.
        run(1'b1, 3);
        run(1'b0, GAP + 1);
        run(1'b1, 3);
        run(1'b0, 10);

        // Reset in WAIT_GAP and in LONG_HELD.
        run(1'b1, 3);
        run(1'b0, 2);
        hold_reset(1'b0, 2);
        run(1'b0, 10);
        run(1'b1, 12);
        hold_reset(1'b0, 2);
        run(1'b0, 10);

        // Randomized level runs with occasional resets.
        lvl = 1'b0;
        for (int s = 0; s < 500; s++) begin
            lvl = ~lvl;
            if ($urandom_range(0, 9) == 0) len = int'($urandom_range(13, 30));
            else                           len = int'($urandom_range(1, 12));
            run(lvl, len);
            if ($urandom_range(0, 49) == 0)
                hold_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        end
        run(1'b0, 12);

        // Let the monitor consume the final expectation.
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
